// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding async_transmitter. Bytes are drained one at a time, and
// TxD_start is pulsed only while the transmitter reports idle. TxD_data is
// held for the whole frame. If TxD_busy never rises after a start, a short
// timeout returns the sequencer to idle so it cannot hang.
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_TO    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  TxD_start,
  output logic [7:0]            TxD_data,
  input  logic                  TxD_busy
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned TimerW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  localparam logic [DEPTH_LOG2:0]   CountOne   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CountFull  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PtrOne     = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [TimerW-1:0]     TimerOne   = {{(TimerW-1){1'b0}}, 1'b1};
  localparam logic [TimerW-1:0]     BusyToLast = TimerW'(BUSY_TO - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2:0]   countNext;
  logic [TimerW-1:0]     busyTimer;
  state_e                state;
  logic                  push;
  logic                  pop;

  // Full is judged on the registered flag, so a write while full is dropped
  // even if a pop happens in the same cycle. Flush wins over a write.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == StIdle) && !empty && !TxD_busy;

  // Next occupancy; flush clears it even when an idle pop happens alongside.
  always_comb begin
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + CountOne;
    end else if (pop && !push) begin
      countNext = count - CountOne;
    end
  end

  // Pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full && !flush;
      count    <= countNext;
      full     <= (countNext == CountFull);
      empty    <= (countNext == '0);
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PtrOne;
        if (pop)  rdPtr <= rdPtr + PtrOne;
      end
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wr_data;
  end

  // Start/busy sequencer with registered TxD_start and TxD_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      TxD_start <= 1'b0;
      TxD_data  <= 8'h00;
      busyTimer <= '0;
    end else begin
      TxD_start <= 1'b0;
      case (state)
        StIdle: begin
          if (pop) begin
            TxD_data  <= mem[rdPtr];
            TxD_start <= 1'b1;
            state     <= StStart;
          end
        end
        StStart: begin
          busyTimer <= '0;
          state     <= StWaitBusy;
        end
        StWaitBusy: begin
          if (TxD_busy) begin
            state <= StWaitDone;
          end else if (busyTimer == BusyToLast) begin
            // Transmitter never acknowledged; treat the byte as sent.
            state <= StIdle;
          end else begin
            busyTimer <= busyTimer + TimerOne;
          end
        end
        StWaitDone: begin
          if (!TxD_busy) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
